// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle processor.
// Latches a read/write request, inserts WAIT_CYCLES wait states, then
// completes the access against an internal RAM and pulses ready for one cycle.
//
// Parameters:
//   DATA_W       data word width
//   ADDR_W       address width (2**ADDR_W words)
//   WAIT_CYCLES  wait states per access (0..15)
//   PROTECT_BASE lowest write-protected address (only with MEM_PROTECT_EN)
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   MemRead   read request, held until ready
//   MemWrite  write request, held until ready
//   addr      access address, sampled on acceptance
//   wdata     write data, sampled on acceptance
//   rdata     registered read data, holds until the next read completes
//   ready     one-cycle completion pulse
//   busy      high from the cycle after acceptance through the ready cycle
//   err       one-cycle error pulse coincident with ready
//
// Optional feature: define MEM_PROTECT_EN to drop writes at addr >= PROTECT_BASE
// (such writes complete with err=1 and leave the RAM unchanged).

module mem_responder #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       WAIT_CYCLES  = 2,
  parameter logic [ADDR_W-1:0] PROTECT_BASE = ADDR_W'(8'hF0)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  // Counter preload; unused when WAIT_CYCLES is 0 (acceptance goes straight to DONE)
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  req_t              req_in;
  req_t              cmp;
  logic [DATA_W-1:0] rdata_d;
  logic              ready_d;
  logic              busy_d;
  logic              err_d;
  logic              enter_done;
  logic              prot_hit;
  logic              fault;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];

  // Incoming request as seen on the ports
  always_comb begin
    req_in.rd    = MemRead;
    req_in.wr    = MemWrite;
    req_in.addr  = addr;
    req_in.wdata = wdata;
  end

  // Request being completed: the live inputs when IDLE jumps straight to DONE
  always_comb begin
    cmp = (state_q == S_IDLE) ? req_in : req_q;
  end

`ifdef MEM_PROTECT_EN
  assign prot_hit = cmp.wr & ~cmp.rd & (cmp.addr >= PROTECT_BASE);
`else
  logic unused_prot;
  assign prot_hit    = 1'b0;
  assign unused_prot = ^PROTECT_BASE;
`endif

  assign fault = (cmp.rd & cmp.wr) | prot_hit;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata;
    ready_d    = 1'b0;
    busy_d     = busy;
    err_d      = 1'b0;
    enter_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemRead | MemWrite) begin
          req_d  = req_in;
          busy_d = 1'b1;
          if (WAIT_CYCLES == 0) begin
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ready/err/rdata are registered on the edge that enters DONE
    if (enter_done) begin
      state_d = S_DONE;
      ready_d = 1'b1;
      err_d   = fault;
      if (cmp.rd & ~cmp.wr) begin
        rdata_d = mem[cmp.addr];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata   <= rdata_d;
      ready   <= ready_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

  // Write commits on the edge leaving DONE; err marks a dropped or illegal write
  assign mem_we = (state_q == S_DONE) & req_q.wr & ~req_q.rd & ~err;

  // Storage array, not reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[req_q.addr] <= req_q.wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: table-driven accesses on a WAIT_CYCLES=2
// instance plus hand-written sequences for reset and WAIT_CYCLES=0 back-to-back.

module tb_mem_responder;

`ifdef MEM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic       clock;
  logic       reset;

  logic       rd, wr;
  logic [7:0] addr, wdata, rdata;
  logic       ready, busy, err;

  logic       rd0, wr0;
  logic [7:0] addr0, wdata0, rdata0;
  logic       ready0, busy0, err0;

  int n_total = 0;
  int n_pass  = 0;

  mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .MemRead(rd), .MemWrite(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .MemRead(rd0), .MemWrite(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_err;
    logic       chk_rd;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One full access on the WAIT_CYCLES=2 instance; ready expected 3 edges after acceptance
  task automatic access(input int idx, input vec_t v);
    int lat;
    lat = 0;
    @(negedge clock);
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    @(posedge clock);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clock);
      if (i == 1) check($sformatf("v%0d busy_after_accept", idx), 32'(busy), 32'd1);
      if (ready) lat = i;
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'd3);
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    if (v.chk_rd) check($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.exp_rdata));
    rd = 1'b0; wr = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d ready_one_cycle", idx), 32'(ready), 32'd0);
    check($sformatf("v%0d busy_cleared", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;

    vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 8'h20, 8'h11, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 8'h11};
    vecs[4]  = '{1'b1, 1'b1, 8'h20, 8'h3C, 1'b1, 1'b1, 8'h11};
    vecs[5]  = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 8'h11};
    vecs[6]  = '{1'b0, 1'b1, 8'h30, 8'h5A, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 8'hF4, 8'h77, PROT, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'hF4, 8'h00, 1'b0, !PROT, 8'h77};
    vecs[9]  = '{1'b0, 1'b1, 8'hEF, 8'h01, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 8'hEF, 8'h00, 1'b0, 1'b1, 8'h01};

    // Reset held for 3 cycles
    repeat (3) @(negedge clock);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst ready", 32'(ready), 32'd0);
    check("rst busy",  32'(busy),  32'd0);
    check("rst err",   32'(err),   32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle ready", 32'(ready), 32'd0);
    check("idle busy",  32'(busy),  32'd0);
    check("idle busy0", 32'(busy0), 32'd0);

    for (int i = 0; i < 11; i++) access(i, vecs[i]);

    // Reset during WAIT of a write to 0x30 abandons the write
    @(negedge clock);
    wr = 1'b1; addr = 8'h30; wdata = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    wr = 1'b0;
    check("midrst busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst busy",  32'(busy),  32'd0);
    check("midrst ready", 32'(ready), 32'd0);
    check("midrst rdata", 32'(rdata), 32'd0);
    check("midrst err",   32'(err),   32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    access(11, '{1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1, 8'h5A});

    // WAIT_CYCLES=0: preload two words, then back-to-back reads with strobe held
    @(negedge clock);
    wr0 = 1'b1; addr0 = 8'h00; wdata0 = 8'hC1;
    @(negedge clock);
    check("w0 write0 ready", 32'(ready0), 32'd1);
    wr0 = 1'b0;
    @(negedge clock);
    wr0 = 1'b1; addr0 = 8'h01; wdata0 = 8'hC2;
    @(negedge clock);
    check("w0 write1 ready", 32'(ready0), 32'd1);
    wr0 = 1'b0;
    @(negedge clock);
    rd0 = 1'b1; addr0 = 8'h00;
    @(negedge clock);
    check("w0 rd0 ready", 32'(ready0), 32'd1);
    check("w0 rd0 rdata", 32'(rdata0), 32'hC1);
    check("w0 rd0 busy",  32'(busy0),  32'd1);
    addr0 = 8'h01;
    @(negedge clock);
    check("w0 gap ready", 32'(ready0), 32'd0);
    check("w0 gap busy",  32'(busy0),  32'd0);
    @(negedge clock);
    check("w0 rd1 ready", 32'(ready0), 32'd1);
    check("w0 rd1 rdata", 32'(rdata0), 32'hC2);
    check("w0 rd1 err",   32'(err0),   32'd0);
    rd0 = 1'b0;
    @(negedge clock);
    check("w0 end ready", 32'(ready0), 32'd0);
    check("w0 hold rdata", 32'(rdata0), 32'hC2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
